// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming(7,4) receive path: codeword layout,
// FSM state type and the syndrome helper.
package hamming_pkg;

  localparam int CW_W  = 7;
  localparam int NIB_W = 4;

  localparam int P1_BIT = 0;
  localparam int P2_BIT = 1;
  localparam int P4_BIT = 3;
  localparam int D_BITS [NIB_W] = '{2, 4, 5, 6};

  typedef logic [2:0] syn_t;

  typedef enum logic {
    ST_LOW  = 1'b0,
    ST_HIGH = 1'b1
  } state_t;

  // Each check bit covers every position whose 1-based index has that bit set.
  function automatic syn_t calc_syndrome(input logic [CW_W-1:0] cw);
    syn_t syn;
    syn = 3'd0;
    for (int i = 0; i < CW_W; i++) begin
      for (int k = 0; k < 3; k++) begin
        if ((((i + 1) >> k) & 1) != 0) begin
          syn[k] = syn[k] ^ cw[i];
        end else begin
          syn[k] = syn[k];
        end
      end
    end
    return syn;
  endfunction

endpackage

// File: rtl/hamming74_correct.sv
// Combinational Hamming(7,4) decoder: syndrome, optional single-bit repair,
// data-nibble extraction and error flag.
import hamming_pkg::*;

module hamming74_correct #(
  parameter bit CORRECT_EN = 1'b1
) (
  input  logic [CW_W-1:0]  codeword_i,
  output logic [NIB_W-1:0] nibble_o,
  output syn_t             syn_o,
  output logic             err_o
);

  logic [CW_W-1:0] flip_mask_s;
  logic [CW_W-1:0] fixed_s;

  // Syndrome, repair mask and nibble extraction from the repaired word.
  always_comb begin
    syn_o = calc_syndrome(codeword_i);
    err_o = (syn_o != 3'd0);
    if (CORRECT_EN && err_o) begin
      flip_mask_s = 7'd1 << (syn_o - 3'd1);
    end else begin
      flip_mask_s = 7'd0;
    end
    fixed_s = codeword_i ^ flip_mask_s;
    for (int i = 0; i < NIB_W; i++) begin
      nibble_o[i] = fixed_s[D_BITS[i]];
    end
  end

endmodule

// File: rtl/hamming_rx_packer.sv
// Hamming(7,4) receive stage: corrects codewords, packs nibble pairs into
// bytes behind a valid/ready output register, counts errored codewords.
import hamming_pkg::*;

module hamming_rx_packer #(
  parameter int ERR_CNT_W  = 16,
  parameter bit CORRECT_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CW_W-1:0]      in_codeword,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_byte,
  output logic [1:0]           out_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  input  logic                 cnt_clr
);

  logic [NIB_W-1:0]     nib_s;
  syn_t                 syn_s;
  logic                 err_s;
  logic                 accept_s;

  state_t               state_q,     state_d;
  logic [NIB_W-1:0]     lo_nib_q,    lo_nib_d;
  logic                 lo_err_q,    lo_err_d;
  logic                 out_valid_q, out_valid_d;
  logic [7:0]           out_byte_q,  out_byte_d;
  logic [1:0]           out_err_q,   out_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q,   err_cnt_d;
  logic [ERR_CNT_W-1:0] cnt_base_s;

  hamming74_correct #(
    .CORRECT_EN (CORRECT_EN)
  ) u_correct (
    .codeword_i (in_codeword),
    .nibble_o   (nib_s),
    .syn_o      (syn_s),
    .err_o      (err_s)
  );

  // HIGH may only accept when the output slot is free or draining this cycle.
  always_comb begin
    in_ready = 1'b1;
    if (state_q == ST_HIGH) begin
      in_ready = !out_valid_q || out_ready;
    end else begin
      in_ready = 1'b1;
    end
    accept_s = in_valid && in_ready;
  end

  // Packer FSM next state and output-register load/drain.
  always_comb begin
    state_d     = state_q;
    lo_nib_d    = lo_nib_q;
    lo_err_d    = lo_err_q;
    out_valid_d = out_valid_q;
    out_byte_d  = out_byte_q;
    out_err_d   = out_err_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    case (state_q)
      ST_LOW: begin
        if (accept_s) begin
          lo_nib_d = nib_s;
          lo_err_d = err_s;
          state_d  = ST_HIGH;
        end else begin
          state_d  = ST_LOW;
        end
      end
      ST_HIGH: begin
        if (accept_s) begin
          out_byte_d  = {nib_s, lo_nib_q};
          out_err_d   = {err_s, lo_err_q};
          out_valid_d = 1'b1;
          state_d     = ST_LOW;
        end else begin
          state_d     = ST_HIGH;
        end
      end
      default: begin
        state_d = ST_LOW;
      end
    endcase
  end

  // Clear is applied before the increment so a coincident error counts as 1.
  always_comb begin
    cnt_base_s = cnt_clr ? {ERR_CNT_W{1'b0}} : err_cnt_q;
    if (accept_s && err_s && !(&cnt_base_s)) begin
      err_cnt_d = cnt_base_s + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      err_cnt_d = cnt_base_s;
    end
  end

  // State, held nibble, output register and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOW;
      lo_nib_q    <= 4'd0;
      lo_err_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_byte_q  <= 8'd0;
      out_err_q   <= 2'd0;
      err_cnt_q   <= {ERR_CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      lo_nib_q    <= lo_nib_d;
      lo_err_q    <= lo_err_d;
      out_valid_q <= out_valid_d;
      out_byte_q  <= out_byte_d;
      out_err_q   <= out_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_byte  = out_byte_q;
  assign out_err   = out_err_q;
  assign err_cnt   = err_cnt_q;

endmodule
